keypad_scanner: RTL and testbench

Input-side counterpart to the four-digit multiplexed seven-segment driver. Drives a 4x4 matrix keypad one column at a time with active-low one-hot strobes, samples the active-low row lines, debounces across full scan frames, and reports each new key as a 4-bit hex code with a one-cycle strobe. A 16-bit digit register holds the last four keys and connects directly to the display driver's 16-bit digit input, with the most recent key in bits [3:0].

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, frame debounce, hex key report.
// Define KEYPAD_DIGITS_EN to build the 16-bit last-four-keys digit register.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV        = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAND,
        S_PRESSED,
        S_REL
    } state_t;

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [15:0] r_div;
    logic [1:0]  r_col_idx;
    logic [3:0]  r_col;
    logic        r_found;
    logic [3:0]  r_fkey;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;

    logic        w_tc;
    logic        w_frame_end;
    logic        w_hit;
    logic [1:0]  w_hit_row;
    logic [3:0]  w_hit_key;
    logic        w_det;
    logic [3:0]  w_det_key;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;
    logic [1:0]  w_idx_nxt;

    function automatic logic [3:0] f_keymap(input logic [3:0] pos);
        logic [3:0] k;
        unique case (pos)
            4'd0:    k = 4'h1;
            4'd1:    k = 4'h4;
            4'd2:    k = 4'h7;
            4'd3:    k = 4'h0;
            4'd4:    k = 4'h2;
            4'd5:    k = 4'h5;
            4'd6:    k = 4'h8;
            4'd7:    k = 4'hF;
            4'd8:    k = 4'h3;
            4'd9:    k = 4'h6;
            4'd10:   k = 4'h9;
            4'd11:   k = 4'hE;
            4'd12:   k = 4'hA;
            4'd13:   k = 4'hB;
            4'd14:   k = 4'hC;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign w_tc        = (r_div == SCAN_DIV - 16'd1);
    assign w_frame_end = w_tc && (r_col_idx == 2'd3);
    assign w_idx_nxt   = r_col_idx + 2'd1;
    assign w_cnt_nxt   = r_cnt + 4'd1;

    // Row 0 is row[3]; the lowest pressed row of this column wins.
    always_comb begin
        w_hit     = 1'b1;
        w_hit_row = 2'd0;
        priority case (1'b1)
            !r_sync2[3]: w_hit_row = 2'd0;
            !r_sync2[2]: w_hit_row = 2'd1;
            !r_sync2[1]: w_hit_row = 2'd2;
            !r_sync2[0]: w_hit_row = 2'd3;
            default:     w_hit     = 1'b0;
        endcase
    end

    assign w_hit_key = f_keymap({r_col_idx, w_hit_row});

    // Columns scan in position order, so an earlier hit in the frame wins.
    assign w_det     = r_found | w_hit;
    assign w_det_key = r_found ? r_fkey : w_hit_key;

    assign w_accept = w_frame_end && w_det &&
        ((r_state == S_IDLE && DEBOUNCE_FRAMES == 4'd1) ||
         (r_state == S_CAND && w_det_key == r_cand &&
          w_cnt_nxt == DEBOUNCE_FRAMES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 4'b1111;
            r_sync2   <= 4'b1111;
            r_div     <= 16'd0;
            r_col_idx <= 2'd0;
            r_col     <= 4'b0111;
            r_found   <= 1'b0;
            r_fkey    <= 4'h0;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
            if (w_tc) begin
                r_div     <= 16'd0;
                r_col_idx <= w_idx_nxt;
                r_col     <= ~(4'b1000 >> w_idx_nxt);
                if (w_frame_end) begin
                    r_found <= 1'b0;
                end else if (!r_found && w_hit) begin
                    r_found <= 1'b1;
                    r_fkey  <= w_hit_key;
                end
            end else begin
                r_div <= r_div + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_det) begin
                            r_cand  <= w_det_key;
                            r_cnt   <= 4'd1;
                            r_state <= w_accept ? S_PRESSED : S_CAND;
                        end
                    end
                    S_CAND: begin
                        if (w_det && w_det_key == r_cand) begin
                            r_cnt <= w_cnt_nxt;
                            if (w_accept) r_state <= S_PRESSED;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (!w_det) begin
                            r_cnt <= 4'd1;
                            if (DEBOUNCE_FRAMES == 4'd1) begin
                                r_state    <= S_IDLE;
                                r_key_held <= 1'b0;
                            end else begin
                                r_state <= S_REL;
                            end
                        end
                    end
                    S_REL: begin
                        if (w_det) begin
                            r_state <= S_PRESSED;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == DEBOUNCE_FRAMES) begin
                                r_state    <= S_IDLE;
                                r_key_held <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            if (w_accept) begin
                r_key_code  <= w_det_key;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
            end
        end
    end

`ifdef KEYPAD_DIGITS_EN
    logic [15:0] r_digits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= 16'h0000;
        end else if (w_accept) begin
            r_digits <= {r_digits[11:0], w_det_key};
        end
    end

    assign digits = r_digits;
`else
    assign digits = 16'h0000;
`endif

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level reference model,
// directed scenarios and randomized key presses (SCAN_DIV=4, DEBOUNCE=2).
module tb_keypad_scanner;

    localparam int SDI = 4;
    localparam int DFI = 2;

`ifdef KEYPAD_DIGITS_EN
    localparam logic [15:0] EXP_D5   = 16'h0005;
    localparam logic [15:0] EXP_DSEQ = 16'h123A;
`else
    localparam logic [15:0] EXP_D5   = 16'h0000;
    localparam logic [15:0] EXP_DSEQ = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    bit pressed [16];
    logic [3:0] kmap [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                              4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE,
                              4'hA, 4'hB, 4'hC, 4'hD};

    // Reference model state (frame-level)
    int          t;
    logic [3:0]  s1, s2;
    bit   [15:0] mask;
    int          cand, cnt, rel;
    bit          held;
    logic [3:0]  m_code;
    bit          m_valid;
    logic [15:0] m_digits;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(16'd4),
        .DEBOUNCE_FRAMES(4'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held),
        .digits(digits)
    );

    // Physical keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col[3-c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) row[3-r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic accept(input int p);
        m_code  = kmap[p];
        m_valid = 1'b1;
`ifdef KEYPAD_DIGITS_EN
        m_digits = {m_digits[11:0], kmap[p]};
`endif
        held = 1'b1;
        cand = -1;
        rel  = 0;
    endtask

    task automatic frame_end();
        int det;
        det = -1;
        for (int p = 0; p < 16; p++)
            if (mask[p] && det < 0) det = p;
        if (!held) begin
            if (cand < 0) begin
                if (det >= 0) begin
                    if (DFI == 1) accept(det);
                    else begin
                        cand = det;
                        cnt  = 1;
                    end
                end
            end else if (det == cand) begin
                cnt++;
                if (cnt == DFI) accept(cand);
            end else begin
                cand = -1;
            end
        end else if (det < 0) begin
            rel++;
            if (rel == DFI) begin
                held = 1'b0;
                rel  = 0;
            end
        end else begin
            rel = 0;
        end
    endtask

    task automatic model_step(input logic rb, input logic [3:0] rw);
        int c;
        if (rb) begin
            t = 0; s1 = 4'hF; s2 = 4'hF; mask = '0;
            cand = -1; cnt = 0; rel = 0; held = 1'b0;
            m_code = 4'h0; m_valid = 1'b0; m_digits = 16'h0000;
        end else begin
            m_valid = 1'b0;
            c = (t / SDI) % 4;
            if (t % SDI == SDI - 1) begin
                for (int r = 0; r < 4; r++)
                    if (!s2[3-r]) mask[c*4+r] = 1'b1;
                if (c == 3) begin
                    frame_end();
                    mask = '0;
                end
            end
            t++;
            s2 = s1;
            s1 = rw;
        end
    endtask

    task automatic tick();
        logic       rb;
        logic [3:0] rw;
        logic [3:0] one;
        #2;
        rb = rst;
        rw = row;
        @(posedge clk);
        #1;
        model_step(rb, rw);
        one = 4'b1000 >> ((t / SDI) % 4);
        check("col", {12'h0, col}, {12'h0, ~one});
        check("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
        check("key_code", {12'h0, key_code}, {12'h0, m_code});
        check("key_held", {15'h0, key_held}, {15'h0, held});
        check("digits", digits, m_digits);
        if (key_valid) pulses++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] hex, input bit v);
        for (int p = 0; p < 16; p++)
            if (kmap[p] == hex) pressed[p] = v;
    endtask

    task automatic release_all();
        for (int p = 0; p < 16; p++) pressed[p] = 1'b0;
    endtask

    initial begin
        release_all();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        check("rst_col", {12'h0, col}, 16'h0007);
        check("rst_code", {12'h0, key_code}, 16'h0000);
        check("rst_valid", {15'h0, key_valid}, 16'h0000);
        check("rst_held", {15'h0, key_held}, 16'h0000);
        check("rst_digits", digits, 16'h0000);
        run(4);
        check("col_after4", {12'h0, col}, 16'h000B);
        run(12);
        check("col_period", {12'h0, col}, 16'h0007);

        pulses = 0;
        press(4'h5, 1'b1);
        run(64);
        check("k5_pulses", 16'(pulses), 16'd1);
        check("k5_code", {12'h0, key_code}, 16'h0005);
        check("k5_held", {15'h0, key_held}, 16'h0001);
        check("k5_digits", digits, EXP_D5);
        press(4'h5, 1'b0);
        run(48);
        check("k5_release", {15'h0, key_held}, 16'h0000);

        for (int i = 0; i < 16 && (t % 16) != 0; i++) tick();
        pulses = 0;
        repeat (3) begin
            press(4'h9, 1'b1);
            run(8);
            press(4'h9, 1'b0);
            run(8);
        end
        run(32);
        check("bounce_pulses", 16'(pulses), 16'd0);

        pulses = 0;
        press(4'h4, 1'b1);
        press(4'hD, 1'b1);
        run(48);
        release_all();
        run(48);
        check("simul_pulses", 16'(pulses), 16'd1);
        check("simul_code", {12'h0, key_code}, 16'h0004);

        pulses = 0;
        press(4'h1, 1'b1); run(48); release_all(); run(48);
        press(4'h2, 1'b1); run(48); release_all(); run(48);
        press(4'h3, 1'b1); run(48); release_all(); run(48);
        press(4'hA, 1'b1); run(48); release_all(); run(48);
        check("seq_pulses", 16'(pulses), 16'd4);
        check("seq_digits", digits, EXP_DSEQ);

        pulses = 0;
        press(4'h7, 1'b1);
        run(48);
        press(4'h8, 1'b1);
        run(48);
        press(4'h7, 1'b0);
        run(48);
        check("roll_pulses", 16'(pulses), 16'd1);
        check("roll_code", {12'h0, key_code}, 16'h0007);
        check("roll_held", {15'h0, key_held}, 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_col", {12'h0, col}, 16'h0007);
        check("mrst_code", {12'h0, key_code}, 16'h0000);
        check("mrst_valid", {15'h0, key_valid}, 16'h0000);
        check("mrst_held", {15'h0, key_held}, 16'h0000);
        check("mrst_digits", digits, 16'h0000);
        release_all();
        run(32);

        repeat (30) begin
            press(4'($urandom_range(0, 15)), 1'b1);
            if ($urandom_range(0, 3) == 0)
                press(4'($urandom_range(0, 15)), 1'b1);
            run($urandom_range(4, 70));
            release_all();
            run($urandom_range(4, 60));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        run(32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
